// File: rtl/clock_step_controller_if.sv
// rtl/clock_step_controller_if.sv - control/status bundle between debug logic and the step controller
interface clock_step_controller_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 32
);
    logic             run_req;
    logic             step_req;
    logic             halt_req;
    logic [DIV_W-1:0] div;
    logic             bp_en;
    logic [CNT_W-1:0] bp_count;
    logic             ce;
    logic             phase;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] ce_count;

    modport master (
        output run_req, step_req, halt_req, div, bp_en, bp_count,
        input  ce, phase, halted, bp_hit, ce_count
    );

    modport slave (
        input  run_req, step_req, halt_req, div, bp_en, bp_count,
        output ce, phase, halted, bp_hit, ce_count
    );
endinterface

// File: rtl/clock_step_controller.sv
// rtl/clock_step_controller.sv - run/halt/single-step clock-enable pacer with cycle-count breakpoint
module clock_step_controller #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    clock_step_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic             ce_r;
    logic             phase_r;
    logic             halted_r;
    logic             bp_hit_r;
    logic [CNT_W-1:0] ce_count_r;

    logic [CNT_W-1:0] count_next;
    logic             bp_match;

    // Breakpoint compares against the post-increment count so the matching pulse is still issued.
    assign count_next = ce_count_r + CNT_W'(1);
    assign bp_match   = bus.bp_en && (count_next == bus.bp_count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_HALT;
            cnt        <= '0;
            ce_r       <= 1'b0;
            phase_r    <= 1'b0;
            halted_r   <= 1'b1;
            bp_hit_r   <= 1'b0;
            ce_count_r <= '0;
        end else begin
            ce_r <= 1'b0;
            case (state)
                S_HALT: begin
                    if (!bus.halt_req) begin
                        if (bus.step_req) begin
                            state    <= S_STEP;
                            cnt      <= bus.div;
                            bp_hit_r <= 1'b0;
                            halted_r <= 1'b0;
                        end else if (bus.run_req) begin
                            state    <= S_RUN;
                            cnt      <= bus.div;
                            bp_hit_r <= 1'b0;
                            halted_r <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.halt_req) begin
                        state    <= S_HALT;
                        halted_r <= 1'b1;
                    end else if (cnt == '0) begin
                        ce_r       <= 1'b1;
                        phase_r    <= ~phase_r;
                        ce_count_r <= count_next;
                        cnt        <= bus.div;
                        if (bp_match) begin
                            state    <= S_HALT;
                            halted_r <= 1'b1;
                            bp_hit_r <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                S_STEP: begin
                    if (bus.halt_req) begin
                        state    <= S_HALT;
                        halted_r <= 1'b1;
                    end else if (cnt == '0) begin
                        ce_r       <= 1'b1;
                        phase_r    <= ~phase_r;
                        ce_count_r <= count_next;
                        state      <= S_HALT;
                        halted_r   <= 1'b1;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                default: begin
                    state    <= S_HALT;
                    halted_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ce       = ce_r;
    assign bus.phase    = phase_r;
    assign bus.halted   = halted_r;
    assign bus.bp_hit   = bp_hit_r;
    assign bus.ce_count = ce_count_r;

endmodule

// File: tb/tb_clock_step_controller.sv
// tb/tb_clock_step_controller.sv - scoreboard bench for clock_step_controller
module tb_clock_step_controller;
    localparam int DIV_W = 8;
    localparam int CNT_W = 5;
    localparam int CMOD  = 1 << CNT_W;

    typedef struct {
        int edge_i;
        bit ph;
        int cnt;
        bit hlt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_step_controller_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    clock_step_controller #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   edge_n = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    bit   m_ph = 1'b0;
    int   m_cnt = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: every ce pulse must match the oldest predicted pulse.
    always @(negedge clk) begin
        if (rst && bus.ce === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ce: got ce=1 at edge %0d expected no pulse", edge_n);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ce_edge", edge_n, e.edge_i);
                check("ce_phase", bus.phase, e.ph);
                check("ce_count", bus.ce_count, e.cnt);
                check("ce_halted", bus.halted, e.hlt);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.run_req = 0; bus.step_req = 0; bus.halt_req = 0; bus.bp_en = 0;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        m_ph = 0;
        m_cnt = 0;
    endtask

    task automatic predict_pulse(input int e, input bit hlt);
        m_ph  = ~m_ph;
        m_cnt = (m_cnt + 1) % CMOD;
        sb.push_back('{e, m_ph, m_cnt, hlt});
    endtask

    // Run with divide d; halt_req is sampled 'hold' edges after the run request.
    task automatic do_run(input int d, input int hold, input bit bpen, input int bpc);
        int k, h, e;
        bit hit;
        k = edge_n + 1;
        h = k + hold;
        hit = 0;
        e = k + 1 + d;
        while (e < h && !hit) begin
            hit = bpen && (((m_cnt + 1) % CMOD) == bpc);
            predict_pulse(e, hit);
            e += d + 1;
        end
        bus.div = DIV_W'(d); bus.bp_en = bpen; bus.bp_count = CNT_W'(bpc);
        bus.run_req = 1;
        tick(1);
        bus.run_req = 0;
        check("run_started", bus.halted, 0);
        check("run_bp_clear", bus.bp_hit, 0);
        while (edge_n < h - 1) tick(1);
        bus.halt_req = 1;
        tick(1);
        bus.halt_req = 0;
        bus.bp_en = 0;
        tick(3);
        check("run_halted", bus.halted, 1);
        check("run_bp_hit", bus.bp_hit, hit);
        check("run_drained", sb.size(), 0);
        check("run_count", bus.ce_count, m_cnt);
        check("run_phase", bus.phase, m_ph);
    endtask

    // Single step; abort>0 samples halt_req that many edges after the request.
    task automatic do_step(input int d, input int abort, input bit also_run);
        int k, fire;
        k = edge_n + 1;
        fire = k + 1 + d;
        if (abort == 0) predict_pulse(fire, 1'b1);
        bus.div = DIV_W'(d);
        bus.step_req = 1;
        bus.run_req = also_run;
        tick(1);
        bus.step_req = 0;
        bus.run_req = 0;
        check("step_started", bus.halted, 0);
        bus.div = DIV_W'($urandom_range(0, 9));
        if (abort > 0) begin
            while (edge_n < k + abort - 1) tick(1);
            bus.halt_req = 1;
            tick(1);
            bus.halt_req = 0;
        end
        while (edge_n < fire + 10) tick(1);
        check("step_halted", bus.halted, 1);
        check("step_drained", sb.size(), 0);
        check("step_count", bus.ce_count, m_cnt);
    endtask

    task automatic do_halt_with(input bit with_step, input bit with_run);
        bus.halt_req = 1; bus.step_req = with_step; bus.run_req = with_run;
        bus.div = DIV_W'($urandom_range(0, 3));
        tick(1);
        bus.halt_req = 0; bus.step_req = 0; bus.run_req = 0;
        check("prio_halted", bus.halted, 1);
        tick(8);
        check("prio_still_halted", bus.halted, 1);
        check("prio_count", bus.ce_count, m_cnt);
    endtask

    initial begin
        int e7, d;
        bus.run_req = 0; bus.step_req = 0; bus.halt_req = 0;
        bus.div = '0; bus.bp_en = 0; bus.bp_count = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_halted", bus.halted, 1);
        check("rst_ce", bus.ce, 0);
        check("rst_phase", bus.phase, 0);
        check("rst_bp_hit", bus.bp_hit, 0);
        check("rst_count", bus.ce_count, 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("idle_halted", bus.halted, 1);

        do_run(0, 10, 0, 0);
        do_run(3, 21, 0, 0);

        do_reset();
        do_step(2, 0, 0);
        do_step(2, 0, 1);
        do_halt_with(1, 0);
        do_halt_with(1, 1);
        do_step(5, 3, 0);
        do_step(5, 6, 0);

        do_reset();
        do_run(1, 40, 1, 4);
        do_run(1, 6, 0, 0);
        do_run(0, 45, 0, 0);
        do_run(0, 60, 1, (m_cnt + CMOD - 2) % CMOD);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 2))
                0: do_run($urandom_range(0, 5), $urandom_range(1, 25),
                          1'($urandom_range(0, 1)), $urandom_range(0, CMOD - 1));
                1: do_step($urandom_range(0, 6), 0, 1'($urandom_range(0, 1)));
                default: do_halt_with(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
        end

        do_reset();
        d = $urandom_range(0, 3);
        e7 = edge_n + 2 + d + 6 * (d + 1);
        for (int j = 0; j < 7; j++) predict_pulse(edge_n + 2 + d + j * (d + 1), 1'b0);
        bus.div = DIV_W'(d);
        bus.run_req = 1;
        tick(1);
        bus.run_req = 0;
        while (edge_n < e7) tick(1);
        #6;
        check("pre_rst_count", bus.ce_count, 7);
        rst = 1'b0;
        #1;
        check("async_halted", bus.halted, 1);
        check("async_ce", bus.ce, 0);
        check("async_phase", bus.phase, 0);
        check("async_bp_hit", bus.bp_hit, 0);
        check("async_count", bus.ce_count, 0);
        check("async_drained", sb.size(), 0);
        sb.delete();
        m_ph = 0;
        m_cnt = 0;
        tick(2);
        rst = 1'b1;
        tick(3);
        check("post_rst_halted", bus.halted, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
